// File: rtl/id_ex_skid_stage.sv
// ---------------------------------------------------------------------------
// id_ex_skid_stage
//
// ID/EX pipeline register with a valid/ready handshake and a 2-entry skid
// buffer. The main register drives the EX side directly; the skid register
// catches one extra beat when EX stalls. This lets in_ready come straight from
// a flop, so there is no combinational path from out_ready back into ID.
// A synchronous flush squashes every held beat and turns the main control
// bundle into a NOP bubble.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   flush          synchronous squash of all held beats (wins over accept/drain)
//   in_valid       ID presents a beat
//   in_ready       stage can accept a beat (registered)
//   in_ctrl/imm/pa/pb/pc/rs_addr/dest   incoming beat payload
//   out_valid      EX-side beat valid
//   out_ready      EX accepts the beat
//   out_ctrl/imm/pa/pb/pc/rs_addr/dest  held beat payload (main register)
//
// Optional feature, enabled by defining ID_EX_SKID_STAGE_PERF_EN:
//   stall_cnt      cycles with out_valid & !out_ready (saturating)
//   flush_cnt      cycles with flush while the stage is not empty (saturating)
// ---------------------------------------------------------------------------
module id_ex_skid_stage #(
   parameter int CTRL_W = 25,
   parameter int IMM_W  = 16,
   parameter int DATA_W = 32,
   parameter int DEST_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,

   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [IMM_W-1:0]  in_imm,
   input  logic [DATA_W-1:0] in_pa,
   input  logic [DATA_W-1:0] in_pb,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [DATA_W-1:0] in_rs_addr,
   input  logic [DEST_W-1:0] in_dest,

   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [IMM_W-1:0]  out_imm,
   output logic [DATA_W-1:0] out_pa,
   output logic [DATA_W-1:0] out_pb,
   output logic [DATA_W-1:0] out_pc,
   output logic [DATA_W-1:0] out_rs_addr,
   output logic [DEST_W-1:0] out_dest
`ifdef ID_EX_SKID_STAGE_PERF_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
`endif
);

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [IMM_W-1:0]  imm;
      logic [DATA_W-1:0] pa;
      logic [DATA_W-1:0] pb;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] rs_addr;
      logic [DEST_W-1:0] dest;
   } beat_t;

   // Encoding chosen so bit 0 is the main valid bit and bit 1 the skid valid
   // bit: both handshake outputs then come straight from state flops.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      TWO   = 2'b11
   } state_t;

   state_t state, state_next;

   logic  main_valid, skid_valid;
   logic  accept, drain;
   logic  main_load_in, main_load_skid, skid_load, bubble;
   beat_t in_beat, main_q, skid_q;

   assign main_valid = state[0];
   assign skid_valid = state[1];

   assign in_ready   = ~skid_valid;
   assign out_valid  = main_valid;

   assign accept = in_valid & in_ready;
   assign drain  = main_valid & out_ready;

   assign in_beat = '{ctrl:    in_ctrl,
                      imm:     in_imm,
                      pa:      in_pa,
                      pb:      in_pb,
                      pc:      in_pc,
                      rs_addr: in_rs_addr,
                      dest:    in_dest};

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   // NOTE: sequential state is written with non-blocking assignments so every
   // flop samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= EMPTY;
      else        state <= state_next;
   end

   // ------------------------------------------------------------------------
   // Next state and datapath steering
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default first; a path that
      // left one unassigned would infer a latch.
      state_next     = state;
      main_load_in   = 1'b0;
      main_load_skid = 1'b0;
      skid_load      = 1'b0;
      bubble         = 1'b0;

      if (flush) begin
         // Squash wins: any beat accepted this cycle is simply not stored.
         state_next = EMPTY;
         bubble     = 1'b1;
      end else begin
         unique case (state)
            EMPTY: begin
               if (accept) begin
                  main_load_in = 1'b1;
                  state_next   = ONE;
               end
            end
            ONE: begin
               if (accept && drain) begin
                  main_load_in = 1'b1;
               end else if (accept) begin
                  skid_load  = 1'b1;
                  state_next = TWO;
               end else if (drain) begin
                  state_next = EMPTY;
               end
            end
            TWO: begin
               // in_ready is low here, so only a drain can move things.
               if (drain) begin
                  main_load_skid = 1'b1;
                  state_next     = ONE;
               end
            end
            default: state_next = EMPTY;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Payload registers
   // ------------------------------------------------------------------------
   // NOTE: these are plain flops, not a RAM, so they take the async reset and
   // present all-zero outputs straight out of reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (bubble) begin
            // Only the control bundle is cleared; the rest of the payload is
            // don't-care once out_valid drops, so it is left untouched.
            main_q.ctrl <= '0;
         end else if (main_load_in) begin
            main_q <= in_beat;
         end else if (main_load_skid) begin
            main_q <= skid_q;
         end

         if (skid_load) skid_q <= in_beat;
      end
   end

   assign out_ctrl    = main_q.ctrl;
   assign out_imm     = main_q.imm;
   assign out_pa      = main_q.pa;
   assign out_pb      = main_q.pb;
   assign out_pc      = main_q.pc;
   assign out_rs_addr = main_q.rs_addr;
   assign out_dest    = main_q.dest;

`ifdef ID_EX_SKID_STAGE_PERF_EN
   // ------------------------------------------------------------------------
   // Saturating performance counters
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (main_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
         if (flush && (state != EMPTY) && (flush_cnt != 32'hFFFF_FFFF))
            flush_cnt <= flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_skid_stage
//
// Self-checking bench for id_ex_skid_stage: a directed vector table covering
// streaming, backpressure and flush, a randomized phase compared against a
// queue-based model of the stage, an asynchronous mid-stream reset, and the
// optional performance counters when ID_EX_SKID_STAGE_PERF_EN is defined.
// ---------------------------------------------------------------------------
module tb_id_ex_skid_stage;

   localparam int CTRL_W = 25;
   localparam int IMM_W  = 16;
   localparam int DATA_W = 32;
   localparam int DEST_W = 5;

   logic              clk = 1'b0;
   logic              reset;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [IMM_W-1:0]  in_imm;
   logic [DATA_W-1:0] in_pa, in_pb, in_pc, in_rs_addr;
   logic [DEST_W-1:0] in_dest;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [IMM_W-1:0]  out_imm;
   logic [DATA_W-1:0] out_pa, out_pb, out_pc, out_rs_addr;
   logic [DEST_W-1:0] out_dest;
`ifdef ID_EX_SKID_STAGE_PERF_EN
   logic [31:0]       stall_cnt, flush_cnt;
`endif

   id_ex_skid_stage #(
      .CTRL_W(CTRL_W), .IMM_W(IMM_W), .DATA_W(DATA_W), .DEST_W(DEST_W)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_ctrl(in_ctrl), .in_imm(in_imm), .in_pa(in_pa), .in_pb(in_pb),
      .in_pc(in_pc), .in_rs_addr(in_rs_addr), .in_dest(in_dest),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_ctrl(out_ctrl), .out_imm(out_imm), .out_pa(out_pa), .out_pb(out_pb),
      .out_pc(out_pc), .out_rs_addr(out_rs_addr), .out_dest(out_dest)
`ifdef ID_EX_SKID_STAGE_PERF_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   // ------------------------------------------------------------------------
   // Reference model: a FIFO of at most two beats. The EX side shows the
   // oldest beat; once it is gone, the last shown beat stays visible, and a
   // flush zeroes its control bundle.
   // ------------------------------------------------------------------------
   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [IMM_W-1:0]  imm;
      logic [DATA_W-1:0] pa;
      logic [DATA_W-1:0] pb;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] rs_addr;
      logic [DEST_W-1:0] dest;
   } beat_t;

   beat_t       q[$];
   beat_t       shown;
   logic [31:0] m_stall, m_flush;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic beat_t cur_in();
      beat_t b;
      b.ctrl = in_ctrl; b.imm = in_imm; b.pa = in_pa; b.pb = in_pb;
      b.pc = in_pc; b.rs_addr = in_rs_addr; b.dest = in_dest;
      return b;
   endfunction

   task automatic model_reset();
      q.delete();
      shown   = '0;
      m_stall = '0;
      m_flush = '0;
   endtask

   // One clock: decide what the model does from the pre-edge inputs, wait for
   // the edge, then apply it. Returns 1 ns after the rising edge.
   task automatic step();
      bit    acc, drn;
      beat_t b;
      acc = in_valid && (q.size() < 2);
      drn = (q.size() > 0) && out_ready;
      b   = cur_in();
      if (q.size() > 0 && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (flush && q.size() > 0 && m_flush != 32'hFFFF_FFFF) m_flush++;
      @(posedge clk);
      #1;
      if (flush) begin
         q.delete();
         shown.ctrl = '0;
      end else begin
         if (drn) void'(q.pop_front());
         if (acc) q.push_back(b);
         if (q.size() > 0) shown = q[0];
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".out_valid"},   64'(out_valid),   64'(q.size() > 0));
      check({tag, ".in_ready"},    64'(in_ready),    64'(q.size() < 2));
      check({tag, ".out_ctrl"},    64'(out_ctrl),    64'(shown.ctrl));
      check({tag, ".out_imm"},     64'(out_imm),     64'(shown.imm));
      check({tag, ".out_pa"},      64'(out_pa),      64'(shown.pa));
      check({tag, ".out_pb"},      64'(out_pb),      64'(shown.pb));
      check({tag, ".out_pc"},      64'(out_pc),      64'(shown.pc));
      check({tag, ".out_rs_addr"}, 64'(out_rs_addr), 64'(shown.rs_addr));
      check({tag, ".out_dest"},    64'(out_dest),    64'(shown.dest));
`ifdef ID_EX_SKID_STAGE_PERF_EN
      check({tag, ".stall_cnt"},   64'(stall_cnt),   64'(m_stall));
      check({tag, ".flush_cnt"},   64'(flush_cnt),   64'(m_flush));
`endif
   endtask

   // Directed stimulus: the non-pc payload fields are derived from pc.
   task automatic drive(input logic fl, input logic iv, input logic ordy,
                        input logic [31:0] pc, input logic [CTRL_W-1:0] ctrl);
      flush      = fl;
      in_valid   = iv;
      out_ready  = ordy;
      in_pc      = pc;
      in_ctrl    = ctrl;
      in_imm     = pc[15:0] ^ 16'h5A5A;
      in_pa      = pc ^ 32'hAAAA_0000;
      in_pb      = pc + 32'h0001_0000;
      in_rs_addr = ~pc;
      in_dest    = pc[6:2];
   endtask

   task automatic drive_random();
      flush      = ($urandom_range(15) == 0);
      in_valid   = ($urandom_range(9) < 7);
      out_ready  = ($urandom_range(9) < 6);
      in_ctrl    = CTRL_W'($urandom);
      in_imm     = IMM_W'($urandom);
      in_pa      = $urandom;
      in_pb      = $urandom;
      in_pc      = $urandom;
      in_rs_addr = $urandom;
      in_dest    = DEST_W'($urandom);
   endtask

   // ------------------------------------------------------------------------
   // Directed vector table: inputs for one cycle and the outputs expected
   // just after that cycle's rising edge.
   // ------------------------------------------------------------------------
   typedef struct {
      logic              fl, iv, ordy;
      logic [31:0]       pc;
      logic [CTRL_W-1:0] ctrl;
      logic              exp_ov, exp_ir;
      logic [31:0]       exp_pc;
      logic [CTRL_W-1:0] exp_ctrl;
   } vec_t;

   vec_t vecs[17];

   function automatic vec_t mkv(input logic fl, input logic iv, input logic ordy,
                                input logic [31:0] pc, input logic [CTRL_W-1:0] ctrl,
                                input logic ov, input logic ir,
                                input logic [31:0] epc, input logic [CTRL_W-1:0] ectrl);
      vec_t v;
      v.fl = fl; v.iv = iv; v.ordy = ordy; v.pc = pc; v.ctrl = ctrl;
      v.exp_ov = ov; v.exp_ir = ir; v.exp_pc = epc; v.exp_ctrl = ectrl;
      return v;
   endfunction

   initial begin
      //                fl iv rdy pc          ctrl      ov ir exp_pc      exp_ctrl
      // streaming, one beat per cycle
      vecs[0]  = mkv(0, 1, 1, 32'h100, 25'h11, 1, 1, 32'h100, 25'h11);
      vecs[1]  = mkv(0, 1, 1, 32'h104, 25'h12, 1, 1, 32'h104, 25'h12);
      vecs[2]  = mkv(0, 1, 1, 32'h108, 25'h13, 1, 1, 32'h108, 25'h13);
      vecs[3]  = mkv(0, 0, 1, 32'h0,   25'h0,  0, 1, 32'h108, 25'h13);
      // backpressure fills the skid, then drains in order
      vecs[4]  = mkv(0, 1, 0, 32'h200, 25'h21, 1, 1, 32'h200, 25'h21);
      vecs[5]  = mkv(0, 1, 0, 32'h204, 25'h22, 1, 0, 32'h200, 25'h21);
      vecs[6]  = mkv(0, 1, 0, 32'h208, 25'h23, 1, 0, 32'h200, 25'h21);
      vecs[7]  = mkv(0, 0, 1, 32'h0,   25'h0,  1, 1, 32'h204, 25'h22);
      vecs[8]  = mkv(0, 0, 1, 32'h0,   25'h0,  0, 1, 32'h204, 25'h22);
      // flush while full, with a beat offered in the same cycle
      vecs[9]  = mkv(0, 1, 0, 32'h2F0, 25'h31, 1, 1, 32'h2F0, 25'h31);
      vecs[10] = mkv(0, 1, 0, 32'h2F4, 25'h32, 1, 0, 32'h2F0, 25'h31);
      vecs[11] = mkv(1, 1, 0, 32'h300, 25'h33, 0, 1, 32'h2F0, 25'h0);
      vecs[12] = mkv(0, 0, 1, 32'h0,   25'h0,  0, 1, 32'h2F0, 25'h0);
      // flush beats a simultaneous accept & drain, then restart
      vecs[13] = mkv(0, 1, 1, 32'h400, 25'h41, 1, 1, 32'h400, 25'h41);
      vecs[14] = mkv(1, 1, 1, 32'h404, 25'h42, 0, 1, 32'h400, 25'h0);
      vecs[15] = mkv(0, 1, 1, 32'h408, 25'h43, 1, 1, 32'h408, 25'h43);
      vecs[16] = mkv(0, 0, 1, 32'h0,   25'h0,  0, 1, 32'h408, 25'h43);

      // ---------------- reset with random inputs ----------------
      reset = 1'b0;
      model_reset();
      drive_random();
      repeat (2) begin
         @(posedge clk);
         #1;
         drive_random();
      end
      check("reset.out_valid", 64'(out_valid), 64'd0);
      check("reset.out_ctrl",  64'(out_ctrl),  64'd0);
      check("reset.out_pc",    64'(out_pc),    64'd0);
      check("reset.in_ready",  64'(in_ready),  64'd1);
      drive(0, 0, 1, 32'h0, '0);
      reset = 1'b1;
      step();
      check_model("post_reset");

      // ---------------- directed table ----------------
      for (int i = 0; i < 17; i++) begin
         drive(vecs[i].fl, vecs[i].iv, vecs[i].ordy, vecs[i].pc, vecs[i].ctrl);
         step();
         check($sformatf("vec%0d.out_valid", i), 64'(out_valid), 64'(vecs[i].exp_ov));
         check($sformatf("vec%0d.in_ready", i),  64'(in_ready),  64'(vecs[i].exp_ir));
         check($sformatf("vec%0d.out_pc", i),    64'(out_pc),    64'(vecs[i].exp_pc));
         check($sformatf("vec%0d.out_ctrl", i),  64'(out_ctrl),  64'(vecs[i].exp_ctrl));
      end

      // ---------------- randomized against the model ----------------
      for (int i = 0; i < 400; i++) begin
         drive_random();
         step();
         check_model($sformatf("rand%0d", i));
      end

      // ---------------- async reset while full ----------------
      drive(1, 0, 0, 32'h0, '0);
      step();
      drive(0, 1, 0, 32'h500, 25'h51);
      step();
      drive(0, 1, 0, 32'h504, 25'h52);
      step();
      check("full.in_ready", 64'(in_ready), 64'd0);
      check("full.out_pc",   64'(out_pc),   64'h500);
      #2;
      reset = 1'b0;
      #1;
      check("async_rst.out_valid", 64'(out_valid), 64'd0);
      check("async_rst.in_ready",  64'(in_ready),  64'd1);
      check("async_rst.out_pc",    64'(out_pc),    64'd0);
      check("async_rst.out_ctrl",  64'(out_ctrl),  64'd0);
      model_reset();
      drive(0, 0, 0, 32'h0, '0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      check_model("after_async_rst");

`ifdef ID_EX_SKID_STAGE_PERF_EN
      // ---------------- performance counters ----------------
      drive(0, 1, 0, 32'h600, 25'h61);
      step();
      drive(0, 0, 0, 32'h0, '0);
      repeat (7) step();
      check("perf.stall_cnt", 64'(stall_cnt), 64'd7);
      drive(1, 0, 1, 32'h0, '0);
      step();
      check("perf.flush_cnt", 64'(flush_cnt), 64'd1);
      check("perf.stall_hold", 64'(stall_cnt), 64'd7);
      check_model("perf");
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/id_ex_skid_stage.md
Name: id_ex_skid_stage

Overview:
- Parametrised ID/EX pipeline register with valid/ready handshake, a 2-entry skid buffer, and synchronous flush (bubble insertion).
- Sits between decode and execute; replaces the unconditional per-cycle capture register.
- Lets EX stall without a combinational ready path back into ID, and lets hazard/branch logic squash in-flight beats.

Parameters:
- CTRL_W, 25, width of the control-signal bundle
- IMM_W, 16, width of the immediate field
- DATA_W, 32, width of PA, PB, PC and RS address fields
- DEST_W, 5, width of the destination register number

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of all held beats
- in_valid  in  1  ID presents a beat
- in_ready  out  1  stage can accept a beat
- in_ctrl  in  CTRL_W  control signals
- in_imm  in  IMM_W  immediate
- in_pa  in  DATA_W  operand A
- in_pb  in  DATA_W  operand B
- in_pc  in  DATA_W  program counter
- in_rs_addr  in  DATA_W  RS address
- in_dest  in  DEST_W  destination register
- out_valid  out  1  EX-side beat valid
- out_ready  in  1  EX accepts beat
- out_ctrl, out_imm, out_pa, out_pb, out_pc, out_rs_addr, out_dest  out  same widths as inputs  held beat payload

Behaviour:
- Definitions: accept = in_valid & in_ready; drain = out_valid & out_ready.
- Storage: main register (drives out_*) and skid register, each with its own valid bit.
- in_ready = !skid_valid. It is a direct register output with no combinational path from out_ready.
- out_valid = main_valid. All out_* are driven directly from main registers.
- States:
  - EMPTY: main and skid both invalid.
  - ONE: main valid only.
  - TWO: main and skid both valid.
- EMPTY:
  - accept: main <= in, go to ONE.
  - else: stay in EMPTY.
- ONE:
  - accept & drain: main <= in, stay in ONE.
  - accept & !drain: skid <= in, go to TWO.
  - !accept & drain: go to EMPTY.
  - neither: hold.
- TWO (in_ready = 0, so no accept is possible):
  - drain: main <= skid, go to ONE.
  - else: hold.
- Latency and throughput: 1 cycle from accept to out_valid when EMPTY. Sustains 1 beat/cycle while out_ready = 1. Strict FIFO order.
- Flush:
  - Next state is EMPTY; main_valid and skid_valid clear; main ctrl clears to 0 (NOP bubble).
  - Any beat accepted in the same cycle is discarded. Flush overrides every accept/drain transition.
  - Non-ctrl payload registers keep their values.
- Payload hold: while out_valid & !out_ready, out_* are bit-stable.
- Reset (asynchronous, active-low):
  - All payload and valid registers are 0; state is EMPTY.
  - out_valid = 0, all out_* = 0, in_ready = 1.
  - Reset asserted mid-transfer drops both entries immediately.
- Register updates occur only on the clk rising edge; reset is the only asynchronous path.

Optional Feature:
- Macro: ID_EX_SKID_STAGE_PERF_EN.
- Defined:
  - Adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - flush_cnt increments each cycle flush = 1 while state != EMPTY.
  - Both saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset: drive reset = 0 with random inputs -> out_valid = 0, out_ctrl = 0, out_pc = 0, in_ready = 1. Release -> state EMPTY.
- Streaming: out_ready = 1; send in_pc = 0x100, 0x104, 0x108 on consecutive cycles -> out_pc shows the same values one cycle later, in_ready stays 1.
- Backpressure: out_ready = 0; send pc 0x200, then 0x204 -> in_ready = 0 after the second beat, out_pc holds 0x200. Raise out_ready -> 0x200 then 0x204 drain in order, in_ready returns 1.
- Flush in TWO: flush = 1 with in_valid = 1 (pc 0x300) -> next cycle out_valid = 0, out_ctrl = 0, in_ready = 1, and 0x300 never appears.
- Async reset mid-stream: drop reset between clock edges while in TWO -> outputs zero immediately, without waiting for a clock edge.
- PERF_EN: hold out_valid = 1 with out_ready = 0 for 7 cycles -> stall_cnt = 7. One flush while ONE -> flush_cnt = 1.
